// File: rtl/sensor_capture.sv
// Pixel capture stage: aligns to a full VD window, tags sof/eol/eof and buffers pixels in a FWFT FIFO.
// Optional line-length check enabled by defining LINE_LEN_CHECK_EN.
module sensor_capture #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int H_ACTIVE   = 57
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hd,
  input  logic          vd,
  input  logic [DW-1:0] pix_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_eof,
  output logic          overflow,
  output logic          line_err,
  output logic [15:0]   frame_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DW + 3;

  typedef enum logic [1:0] {WAIT_LOW, WAIT_SOF, CAPTURE} state_t;

  state_t          state, state_nxt;
  logic            sof_flag;
  logic            pend_valid;
  logic [DW-1:0]   pend_data;
  logic            pend_sof;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic [EW-1:0]   head;
  logic            sample, push, push_eol, push_eof, pop, full, wr_en;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= WAIT_LOW;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOW: if (!vd) state_nxt = WAIT_SOF;
      WAIT_SOF: if (vd)  state_nxt = CAPTURE;
      CAPTURE:  if (!vd) state_nxt = WAIT_SOF;
      default:  state_nxt = WAIT_LOW;
    endcase
  end

  // The pending register delays each sample by one so the hd/vd fall can tag it.
  assign sample   = (state == CAPTURE) && hd && vd;
  assign push     = pend_valid && (sample || !hd);
  assign push_eol = !hd;
  assign push_eof = !hd && !vd;
  assign pop      = out_valid && out_ready;
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign wr_en    = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sof_flag   <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_sof   <= 1'b0;
      frame_cnt  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (state == WAIT_SOF && vd) sof_flag <= 1'b1;
      else if (sample)             sof_flag <= 1'b0;
      if (sample) begin
        pend_valid <= 1'b1;
        pend_data  <= pix_data;
        pend_sof   <= sof_flag;
        if (sof_flag) frame_cnt <= frame_cnt + 16'd1;
      end else if (push) begin
        pend_valid <= 1'b0;
      end
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= {pend_data, pend_sof, push_eol && !sample, push_eof && !sample};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (pop)   rptr <= rptr + AW'(1);
      if (wr_en && !pop)      count <= count + (AW+1)'(1);
      else if (!wr_en && pop) count <= count - (AW+1)'(1);
    end
  end

  assign head      = mem[rptr];
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? head[EW-1:3] : '0;
  assign out_sof   = out_valid && head[2];
  assign out_eol   = out_valid && head[1];
  assign out_eof   = out_valid && head[0];

`ifdef LINE_LEN_CHECK_EN
  localparam int LW = $clog2(H_ACTIVE + 1);
  logic [LW-1:0] line_len;
  logic          line_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_len   <= '0;
      line_err_q <= 1'b0;
    end else if (push && push_eol) begin
      line_len <= '0;
      if (line_len != LW'(H_ACTIVE)) line_err_q <= 1'b1;
    end else if (sample && line_len != '1) begin
      line_len <= line_len + LW'(1);
    end
  end

  assign line_err = line_err_q;
`else
  // Constant-false expression keeps H_ACTIVE referenced when the check is not built.
  assign line_err = (H_ACTIVE < 0);
`endif

endmodule

// File: tb/tb_sensor_capture.sv
// Directed bench for sensor_capture: table of frame scenarios plus hand-written corner sequences.
module tb_sensor_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hd = 1'b0;
  logic        vd = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof, out_eol, out_eof, overflow, line_err;
  logic [15:0] frame_cnt;

`ifdef LINE_LEN_CHECK_EN
  localparam logic LERR = 1'b1;
`else
  localparam logic LERR = 1'b0;
`endif

  sensor_capture #(.DW(8), .FIFO_DEPTH(16), .H_ACTIVE(57)) dut (
    .clk(clk), .rst_n(rst_n), .hd(hd), .vd(vd), .pix_data(pix_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .overflow(overflow), .line_err(line_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  typedef struct {
    int   nf;
    int   nl;
    int   np;
    int   exp_out;
    int   exp_fc;
    logic exp_ovf;
    logic exp_lerr;
  } vec_t;

  pix_t exp_q[$];
  int   n_vec = 0, n_fail = 0;
  int   n_out, n_sof, n_eol, n_eof;
  int   pix_seed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    pix_t got, e;
    if (rst_n && out_valid && out_ready) begin
      got = {out_data, out_sof, out_eol, out_eof};
      n_out++;
      n_sof += int'(out_sof);
      n_eol += int'(out_eol);
      n_eof += int'(out_eof);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL extra_pixel: got %0h expected none", got);
      end else begin
        e = exp_q.pop_front();
        check("pixel", 32'(got), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_out = 0; n_sof = 0; n_eol = 0; n_eof = 0;
  endtask

  // Reset while a frame is in progress, then finish that frame so it is discarded.
  task automatic reset_pre();
    rst_n = 1'b0; vd = 1'b1; hd = 1'b1; pix_data = 8'hAA;
    tick(); tick();
    rst_n = 1'b1;
    for (int l = 0; l < 3; l++) begin
      hd = 1'b1;
      for (int p = 0; p < 10; p++) begin pix_data = 8'(pix_seed); pix_seed++; tick(); end
      hd = 1'b0;
      repeat (4) tick();
    end
    vd = 1'b0; hd = 1'b0;
    repeat (5) tick();
    clear_counts();
  endtask

  task automatic drive_frame(input int nl, input int np, input bit capture, input bit rdy_at_end);
    pix_t e;
    vd = 1'b1; hd = 1'b0;
    repeat (3) tick();
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < np; p++) begin
        hd = 1'b1;
        pix_data = 8'(pix_seed);
        pix_seed++;
        if (capture) begin
          e.d   = pix_data;
          e.sof = (l == 0 && p == 0);
          e.eol = (p == np - 1);
          e.eof = (l == nl - 1 && p == np - 1);
          exp_q.push_back(e);
        end
        tick();
      end
      if (l == nl - 1) begin
        hd = 1'b0; vd = 1'b0;
        if (rdy_at_end) out_ready = 1'b1;
        tick();
      end else begin
        hd = 1'b0;
        repeat (4) tick();
      end
    end
    vd = 1'b0; hd = 1'b0;
    repeat (5) tick();
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 5000) begin tick(); t++; end
    check({name, "_drain_timeout"}, 32'(t < 5000), 32'd1);
    check({name, "_missing"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{nf: 2, nl: 28, np: 57, exp_out: 3192, exp_fc: 2, exp_ovf: 1'b0, exp_lerr: 1'b0};
    vecs[1] = '{nf: 1, nl: 3,  np: 57, exp_out: 171,  exp_fc: 1, exp_ovf: 1'b0, exp_lerr: 1'b0};
    vecs[2] = '{nf: 1, nl: 1,  np: 56, exp_out: 56,   exp_fc: 1, exp_ovf: 1'b0, exp_lerr: LERR};
    vecs[3] = '{nf: 3, nl: 2,  np: 57, exp_out: 342,  exp_fc: 3, exp_ovf: 1'b0, exp_lerr: 1'b0};
    clear_counts();

    rst_n = 1'b0; vd = 1'b1; hd = 1'b1;
    tick();
    check("rst_outputs", 32'({out_valid, out_data, out_sof, out_eol, out_eof, overflow, line_err}), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      reset_pre();
      check("discard_partial", 32'(out_valid), 32'd0);
      for (int f = 0; f < vecs[i].nf; f++) drive_frame(vecs[i].nl, vecs[i].np, 1'b1, 1'b0);
      drain("vec");
      check("vec_out_count", 32'(n_out), 32'(vecs[i].exp_out));
      check("vec_sof_count", 32'(n_sof), 32'(vecs[i].nf));
      check("vec_eol_count", 32'(n_eol), 32'(vecs[i].nf * vecs[i].nl));
      check("vec_eof_count", 32'(n_eof), 32'(vecs[i].nf));
      check("vec_frame_cnt", 32'(frame_cnt), 32'(vecs[i].exp_fc));
      check("vec_overflow", 32'(overflow), 32'(vecs[i].exp_ovf));
      check("vec_line_err", 32'(line_err), 32'(vecs[i].exp_lerr));
    end

    // Stall a full line: only the first 16 pixels survive and the head holds.
    out_ready = 1'b0;
    reset_pre();
    pix_seed = 8'h40;
    drive_frame(1, 57, 1'b0, 1'b0);
    check("stall_overflow", 32'(overflow), 32'd1);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_hold_data", 32'(out_data), 32'h40);
    check("stall_hold_sof", 32'(out_sof), 32'd1);
    check("stall_frame_cnt", 32'(frame_cnt), 32'd1);
    for (int k = 0; k < 16; k++) begin
      pix_t e;
      e.d = 8'(8'h40 + k); e.sof = (k == 0); e.eol = 1'b0; e.eof = 1'b0;
      exp_q.push_back(e);
    end
    out_ready = 1'b1;
    drain("stall");
    check("stall_out_count", 32'(n_out), 32'd16);

    // FIFO full exactly when the eol push arrives, with a pop in the same cycle.
    out_ready = 1'b0;
    reset_pre();
    drive_frame(1, 17, 1'b1, 1'b1);
    drain("fullpop");
    check("fullpop_overflow", 32'(overflow), 32'd0);
    check("fullpop_out_count", 32'(n_out), 32'd17);
    check("fullpop_eof_count", 32'(n_eof), 32'd1);

    // One-cycle reset mid-line with 10 pixels buffered.
    out_ready = 1'b0;
    reset_pre();
    vd = 1'b1; hd = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 11; k++) begin hd = 1'b1; pix_data = 8'(k); tick(); end
    check("midrst_prefill_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    clear_counts();
    for (int k = 0; k < 20; k++) begin hd = 1'b1; pix_data = 8'(k + 11); tick(); end
    hd = 1'b0;
    repeat (4) tick();
    vd = 1'b0;
    repeat (5) tick();
    check("midrst_no_output", 32'(n_out), 32'd0);
    drive_frame(1, 57, 1'b1, 1'b0);
    drain("midrst");
    check("midrst_out_count", 32'(n_out), 32'd57);
    check("midrst_frame_cnt_after", 32'(frame_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
